// File: rtl/alu_seq_pkg.sv
// Shared types and the 7-segment decoder for the sequential BCD ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_EQ
  } op_t;

  typedef enum logic [2:0] {
    IDLE, EXEC, CONV_A, CONV_B, CONV_R, DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low gfedcba; non-decimal codes render blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: load, then WIDTH shift/add-3 cycles.
// bcd is the result of the current step, valid flags the final step.
module bin2bcd_seq #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  valid
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    sh;
  logic [DIGITS*4-1:0] acc, adj;
  logic [CW-1:0]       cnt;

  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++)
      if (acc[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    bcd = {adj[DIGITS*4-2:0], sh[WIDTH-1]};
  end

  assign valid = (cnt == CW'(1));

  // A load wins over a step so the next conversion can start on the final-step edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= bin;
      acc <= '0;
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      sh  <= {sh[WIDTH-2:0], 1'b0};
      acc <= bcd;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_bcd.sv
// Clocked 8-op ALU with shared sequential BCD conversion to three 7-seg groups.
// Optional SIGN_MAG_EN: show negative add/sub/logic results as a negated magnitude.
module alu_seq_bcd
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  load_a,
  input  logic                  load_b,
  input  logic [2:0]            op,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  carry,
  output logic                  overflow,
  output logic                  zero,
  output logic                  neg,
  output logic [DIGITS*7-1:0]   seg_a,
  output logic [DIGITS*7-1:0]   seg_b,
  output logic [DIGITS*7-1:0]   seg_r
);
  state_t              state, nstate;
  op_t                 op_r;
  logic [WIDTH-1:0]    a, b, d, raw, disp, cbin;
  logic                c, ov, z, n, arith;
  logic                cload, cvalid;
  logic [DIGITS*4-1:0] cbcd;
  logic [DIGITS*7-1:0] segs;

  always_comb begin
    c   = 1'b0;
    ov  = 1'b0;
    raw = '0;
    case (op_r)
      OP_ADD: begin
        {c, raw} = {1'b0, a} + {1'b0, b};
        ov = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {c, raw} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        ov = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT: raw = ~a;
      OP_AND: raw = a & b;
      OP_OR:  raw = a | b;
      OP_XOR: raw = a ^ b;
      OP_CMP: raw = (a > b) ? '0 : (a < b) ? WIDTH'(1) : WIDTH'(2);
      OP_EQ:  raw = (a == b) ? '0 : WIDTH'(1);
      default: raw = '0;
    endcase
    arith = (op_r != OP_CMP) && (op_r != OP_EQ);
    z     = arith && (raw == '0);
`ifdef SIGN_MAG_EN
    n    = arith && raw[WIDTH-1];
    disp = n ? (~raw + WIDTH'(1)) : raw;
`else
    n    = 1'b0;
    disp = raw;
`endif
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = EXEC;
      EXEC:    nstate = CONV_A;
      CONV_A:  if (cvalid) nstate = CONV_B;
      CONV_B:  if (cvalid) nstate = CONV_R;
      CONV_R:  if (cvalid) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  // Each CONV state's final step is also the load edge of the next conversion.
  assign cload = (state == EXEC) || (cvalid && (state == CONV_A || state == CONV_B));
  assign cbin  = (state == EXEC) ? a : (state == CONV_A) ? b : d;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .load  (cload),
    .bin   (cbin),
    .bcd   (cbcd),
    .valid (cvalid)
  );

  always_comb begin
    segs = '1;
    for (int i = 0; i < DIGITS; i++) segs[i*7 +: 7] = seg7(cbcd[i*4 +: 4]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_r     <= OP_ADD;
      a        <= '0;
      b        <= '0;
      d        <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      seg_a    <= {DIGITS{SEG_BLANK}};
      seg_b    <= {DIGITS{SEG_BLANK}};
      seg_r    <= {DIGITS{SEG_BLANK}};
    end else begin
      state <= nstate;
      if (state == IDLE) begin
        if (load_a) a <= data_in;
        if (load_b) b <= data_in;
        if (start)  op_r <= op_t'(op);
      end
      if (state == EXEC) begin
        carry    <= c;
        overflow <= ov;
        zero     <= z;
        neg      <= n;
        d        <= disp;
      end
      if (cvalid && state == CONV_A) seg_a <= segs;
      if (cvalid && state == CONV_B) seg_b <= segs;
      if (cvalid && state == CONV_R) seg_r <= segs;
    end
  end

endmodule

// File: tb/tb_alu_seq_bcd.sv
// Self-checking bench for alu_seq_bcd: directed table, random ops, abort/ignore sequences.
module tb_alu_seq_bcd;
  localparam int W   = 7;
  localparam int M   = 1 << W;
  localparam int LAT = 3 * W + 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic [6:0]  data_in = '0;
  logic        load_a = 1'b0, load_b = 1'b0, start = 1'b0;
  logic [2:0]  op = '0;
  logic        busy, done, carry, overflow, zero, neg;
  logic [20:0] seg_a, seg_b, seg_r;

  int checks = 0;
  int errors = 0;

  alu_seq_bcd #(.WIDTH(W), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_a(load_a), .load_b(load_b),
    .op(op), .start(start), .busy(busy), .done(done), .carry(carry),
    .overflow(overflow), .zero(zero), .neg(neg),
    .seg_a(seg_a), .seg_b(seg_b), .seg_r(seg_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a, b, op;
    int carry, ovf, zero, neg, d;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [6:0] dig7(input int v);
    case (v)
      0: dig7 = 7'b1000000; 1: dig7 = 7'b1111001; 2: dig7 = 7'b0100100;
      3: dig7 = 7'b0110000; 4: dig7 = 7'b0011001; 5: dig7 = 7'b0010010;
      6: dig7 = 7'b0000010; 7: dig7 = 7'b1111000; 8: dig7 = 7'b0000000;
      default: dig7 = 7'b0010000;
    endcase
  endfunction

  function automatic logic [20:0] seg_of(input int v);
    logic [20:0] r;
    int x = v;
    for (int i = 0; i < 3; i++) begin
      r[i*7 +: 7] = dig7(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic vec_t model(input int a, input int b, input int o);
    vec_t e;
    int sa = (a >= M/2) ? a - M : a;
    int sb = (b >= M/2) ? b - M : b;
    int raw = 0, ss = 0;
    e.a = a; e.b = b; e.op = o;
    e.carry = 0; e.ovf = 0; e.neg = 0;
    case (o)
      0: begin raw = (a + b) % M; e.carry = int'(a + b >= M); ss = sa + sb;
               e.ovf = int'(ss > M/2 - 1 || ss < -M/2); end
      1: begin raw = (a - b + M) % M; e.carry = int'(a >= b); ss = sa - sb;
               e.ovf = int'(ss > M/2 - 1 || ss < -M/2); end
      2: raw = (M - 1) - a;
      3: raw = a & b;
      4: raw = a | b;
      5: raw = a ^ b;
      6: raw = (a > b) ? 0 : (a < b) ? 1 : 2;
      default: raw = (a == b) ? 0 : 1;
    endcase
    e.zero = int'(o < 6 && raw == 0);
    e.d = raw;
`ifdef SIGN_MAG_EN
    if (o < 6 && raw >= M/2) begin e.neg = 1; e.d = M - raw; end
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    int nc = 1;
    while (done !== 1'b1 && nc < 200) begin
      @(negedge clk);
      nc++;
    end
    lat = nc;
  endtask

  // B loaded alone, A loaded in the same cycle as start.
  task automatic launch(input int a, input int b, input int o);
    @(negedge clk);
    data_in = 7'(b); load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0; data_in = 7'(a); load_a = 1'b1; op = 3'(o); start = 1'b1;
    @(negedge clk);
    load_a = 1'b0; start = 1'b0;
  endtask

  task automatic finish_check(input string tag, input vec_t e, input int lat);
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " carry"}, carry, e.carry);
    chk({tag, " ovf"}, overflow, e.ovf);
    chk({tag, " zero"}, zero, e.zero);
    chk({tag, " neg"}, neg, e.neg);
    chk({tag, " seg_a"}, seg_a, seg_of(e.a));
    chk({tag, " seg_b"}, seg_b, seg_of(e.b));
    chk({tag, " seg_r"}, seg_r, seg_of(e.d));
    @(negedge clk);
    chk({tag, " done_pulse"}, {busy, done}, 2'b00);
  endtask

  task automatic run_op(input string tag, input vec_t e);
    int lat;
    launch(e.a, e.b, e.op);
    wait_done(lat);
    finish_check(tag, e, lat);
  endtask

  initial begin
    int lat;
    vec_t e;
    tbl[0] = '{25, 17, 0, 0, 0, 0, 0, 42};
`ifdef SIGN_MAG_EN
    tbl[1] = '{5, 9, 1, 0, 0, 0, 1, 4};
    tbl[2] = '{60, 10, 0, 0, 1, 0, 1, 58};
    tbl[8] = '{0, 64, 1, 0, 1, 0, 1, 64};
`else
    tbl[1] = '{5, 9, 1, 0, 0, 0, 0, 124};
    tbl[2] = '{60, 10, 0, 0, 1, 0, 0, 70};
    tbl[8] = '{0, 64, 1, 0, 1, 0, 0, 64};
`endif
    tbl[3] = '{64, 64, 0, 1, 1, 1, 0, 0};
    tbl[4] = '{33, 33, 6, 0, 0, 0, 0, 2};
    tbl[5] = '{33, 33, 7, 0, 0, 0, 0, 0};
    tbl[6] = '{33, 34, 6, 0, 0, 0, 0, 1};
    tbl[7] = '{127, 0, 2, 0, 0, 1, 0, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset seg_a", seg_a, {21{1'b1}});
    chk("reset seg_b", seg_b, {21{1'b1}});
    chk("reset seg_r", seg_r, {21{1'b1}});
    chk("reset status", {busy, done, carry, overflow, zero, neg}, 6'b0);

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 30; i++) begin
      e = model(int'($urandom_range(M - 1)), int'($urandom_range(M - 1)),
                int'($urandom_range(7)));
      run_op($sformatf("rnd%0d", i), e);
    end

    // Loads and start while busy must not disturb the running op.
    launch(11, 3, 0);
    repeat (4) @(negedge clk);
    data_in = 7'd99; load_a = 1'b1; load_b = 1'b1; start = 1'b1; op = 3'd1;
    @(negedge clk);
    load_a = 1'b0; load_b = 1'b0; start = 1'b0;
    chk("ign busy", busy, 1'b1);
    wait_done(lat);
    lat = lat + 5;
    finish_check("ign", model(11, 3, 0), lat);
    @(negedge clk);
    op = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    finish_check("ign rerun", model(11, 3, 0), lat);

    // Abort during the B conversion.
    launch(100, 100, 0);
    repeat (11) @(negedge clk);
    chk("abort pre seg_a", seg_a, seg_of(100));
    chk("abort pre busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort busy", {busy, done}, 2'b00);
    chk("abort seg_a", seg_a, {21{1'b1}});
    chk("abort seg_r", seg_r, {21{1'b1}});
    chk("abort flags", {carry, overflow, zero, neg}, 4'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    finish_check("post_rst zeroab", model(0, 0, 0), lat);
    run_op("post_rst op", model(2, 3, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
